// File: rtl/mem_access_unit_pkg.sv
// Shared widths, access-kind codes and FSM state encoding for the memory
// access unit and its IR assembler.
package mem_access_unit_pkg;

    localparam int ADDR_WIDTH        = 16;
    localparam int DATA_WIDTH        = 16;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int MAX_WAIT          = 15;

    typedef enum logic [1:0] {
        ACC_FETCH = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } acc_kind_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mau_state_e;

    // Fetch beats store beats load; a load is whatever remains once start fired.
    function automatic acc_kind_e decode_kind(input logic ireg_we, input logic data_acc,
                                              input logic wr);
        if (ireg_we)
            return ACC_FETCH;
        else if (data_acc && wr)
            return ACC_STORE;
        else
            return ACC_LOAD;
    endfunction

endpackage

// File: rtl/mem_access_unit_ir_assembler.sv
// Instruction register built from two independently written halves.
// Ports:
//   clk, rst_n   clock, asynchronous active-low clear
//   we_hi_i      load din_i into instr_o[2W-1:W]
//   we_lo_i      load din_i into instr_o[W-1:0]
//   din_i        half-word from memory
//   instr_o      assembled instruction (all-zero after reset decodes as NOP)
module mem_access_unit_ir_assembler #(
    parameter int HALF_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_hi_i,
    input  logic                    we_lo_i,
    input  logic [HALF_WIDTH-1:0]   din_i,
    output logic [2*HALF_WIDTH-1:0] instr_o
);

    logic [HALF_WIDTH-1:0] hi_q;
    logic [HALF_WIDTH-1:0] lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (we_hi_i) hi_q <= din_i;
            if (we_lo_i) lo_q <= din_i;
        end
    end

    assign instr_o = {hi_q, lo_q};

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns the control FSM's fetch/load/store strobes into a
// req/ack transaction on a variable-latency 16-bit memory, assembles the IR,
// holds the MDR and aborts accesses that wait too long.
// Handshake: a strobe is accepted only while IDLE (busy then goes high
// combinationally); mem_req/mem_addr/mem_we/mem_wdata are registered and stay
// stable until the one-cycle mem_ack pulse or the wait limit, after which
// mem_req drops on the next edge. mem_ack outside an access is ignored.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   pc, alu_out, store_data         fetch address, data address, store value
//   ireg_write_enable, hi_half,
//   data_or_not_inst, mem_read,
//   mem_write                       access strobes from control
//   mem_addr, mem_wdata, mem_req,
//   mem_we, mem_rdata, mem_ack      external memory interface
//   instruction, mdr                assembled IR and last loaded word
//   busy, timeout_err               stall request and sticky abort flag
//   dbg_state                       current FSM state for observation
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH        = mem_access_unit_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH        = mem_access_unit_pkg::DATA_WIDTH,
    parameter int INSTRUCTION_WIDTH = mem_access_unit_pkg::INSTRUCTION_WIDTH,
    parameter int MAX_WAIT          = mem_access_unit_pkg::MAX_WAIT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        pc,
    input  logic [ADDR_WIDTH-1:0]        alu_out,
    input  logic [DATA_WIDTH-1:0]        store_data,
    input  logic                         ireg_write_enable,
    input  logic                         hi_half,
    input  logic                         data_or_not_inst,
    input  logic                         mem_read,
    input  logic                         mem_write,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic                         mem_req,
    output logic                         mem_we,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    input  logic                         mem_ack,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0]        mdr,
    output logic                         busy,
    output logic                         timeout_err,
    output mau_state_e                   dbg_state
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);

    mau_state_e            state_q,   state_d;
    acc_kind_e             kind_q,    kind_d;
    logic                  hi_q,      hi_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic                  we_q,      we_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] mdr_q,     mdr_d;

    logic      start;
    acc_kind_e kind_w;
    logic      ir_we_hi;
    logic      ir_we_lo;

    assign start  = (state_q == ST_IDLE) &&
                    (ireg_write_enable || (data_or_not_inst && (mem_read || mem_write)));
    assign kind_w = decode_kind(ireg_write_enable, data_or_not_inst, mem_write);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            kind_q    <= ACC_FETCH;
            hi_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            hi_q      <= hi_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            mdr_q     <= mdr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        hi_d      = hi_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        mdr_d     = mdr_q;
        ir_we_hi  = 1'b0;
        ir_we_lo  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = (kind_w == ACC_FETCH) ? pc : alu_out;
                    wdata_d = store_data;
                    we_d    = (kind_w == ACC_STORE);
                    kind_d  = kind_w;
                    hi_d    = hi_half;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // The ack is checked first so an ack on the last allowed
                // cycle completes the access instead of aborting it.
                if (mem_ack) begin
                    if (kind_q == ACC_FETCH) begin
                        ir_we_hi = hi_q;
                        ir_we_lo = !hi_q;
                    end else if (kind_q == ACC_LOAD) begin
                        mdr_d = mem_rdata;
                    end
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    we_d      = 1'b0;
                    state_d   = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mem_access_unit_ir_assembler #(
        .HALF_WIDTH (DATA_WIDTH)
    ) u_ir (
        .clk     (clk),
        .rst_n   (reset),
        .we_hi_i (ir_we_hi),
        .we_lo_i (ir_we_lo),
        .din_i   (mem_rdata),
        .instr_o (instruction)
    );

    assign mem_req     = (state_q == ST_ACCESS);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_we      = we_q;
    assign mdr         = mdr_q;
    assign timeout_err = timeout_q;
    assign busy        = start || (state_q == ST_ACCESS);
    assign dbg_state   = state_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side neighbour of the multicycle control FSM.
- Consumes the FSM's memory and IR strobes: ireg_write_enable, hi_half, data_or_not_inst, mem_read, mem_write.
- Runs a req/ack handshake to a variable-latency 16-bit external memory.
- Assembles the 32-bit instruction register from two 16-bit halves, holds the memory data register (MDR) for loads, and reports busy/timeout.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH, 16, memory word width.
- INSTRUCTION_WIDTH, 32, IR width; must equal 2*DATA_WIDTH.
- MAX_WAIT, 15, cycles with mem_req high and no ack before abort.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  ADDR_WIDTH  fetch address.
- alu_out  in  ADDR_WIDTH  data address for load/store.
- store_data  in  DATA_WIDTH  register value for a store.
- ireg_write_enable  in  1  fetch request from control.
- hi_half  in  1  fetch targets instruction[31:16] when 1, [15:0] when 0.
- data_or_not_inst  in  1  data access (1) or instruction fetch (0).
- mem_read  in  1  read qualifier for data access.
- mem_write  in  1  write qualifier for data access.
- mem_addr  out  ADDR_WIDTH  registered memory address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_req  out  1  registered request.
- mem_we  out  1  registered write enable, valid while mem_req=1.
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse.
- instruction  out  INSTRUCTION_WIDTH  assembled IR, fed to control.
- mdr  out  DATA_WIDTH  last loaded data word.
- busy  out  1  access in progress; control holds state while high.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mem_req, mem_we, busy, timeout_err = 0; mem_addr, mem_wdata, instruction, mdr = 0. instruction=0 decodes as NOP.
- start = IDLE & (ireg_write_enable | (data_or_not_inst & (mem_read | mem_write))).
- Kind decode, priority in this order:
  - FETCH when ireg_write_enable=1.
  - STORE when data_or_not_inst & mem_write.
  - LOAD otherwise.
- States: IDLE, ACCESS.
- IDLE, start seen at cycle T0 edge:
  - Latch mem_addr = FETCH ? pc : alu_out.
  - Latch mem_wdata = store_data, mem_we = (kind==STORE), plus kind and hi_half.
  - Clear wait counter; go to ACCESS; mem_req=1 from T1.
- ACCESS, mem_ack=1:
  - FETCH: hi_half_latched ? instruction[31:16] : instruction[15:0] <= mem_rdata; the other half is unchanged.
  - LOAD: mdr <= mem_rdata.
  - STORE: no capture.
  - Go to IDLE; mem_req and mem_we drop the next cycle.
- ACCESS, no ack: counter increments. When counter==MAX_WAIT-1 and still no ack:
  - Set timeout_err=1 (sticky until reset).
  - Go to IDLE; mem_req drops; instruction and mdr unchanged.
- Simultaneous ack and timeout in the same cycle: ack wins; no error.
- busy = start | (state==ACCESS), combinational. Ack-to-busy-low latency is 0 cycles: busy is low in the cycle after the ack edge.
- Minimum access is 2 cycles (T0 start, T1 req with immediate ack).
- Strobes arriving while in ACCESS are ignored; control holds them until busy falls.
- mem_ack while IDLE is ignored.
- Counter is $clog2(MAX_WAIT+1) bits; it saturates and never wraps.
- Reset asserted mid-access: mem_req drops immediately; the partial instruction is discarded (IR cleared).

Decomposition:
- params.v holds INSTRUCTION_WIDTH, DATA_WIDTH, ADDR_WIDTH, and access-kind codes ACC_FETCH=2'd0, ACC_LOAD=2'd1, ACC_STORE=2'd2.
- One natural sub-module, ir_assembler: two 16-bit halves with a per-half write enable and async clear. Everything else stays inline.

Test Plan:
- Fetch pair: pc=0x0010, hi_half=1, ack on T1 with rdata=0x1234; then pc=0x0012, hi_half=0, ack on T2 with rdata=0x5678 -> instruction=0x12345678; mem_addr 0x0010 then 0x0012; busy high exactly 2 cycles per half.
- Load with wait states: alu_out=0x0100, ack 4 cycles after req, rdata=0xBEEF -> mdr=0xBEEF; mem_we=0 throughout; instruction unchanged.
- Store: alu_out=0x0200, store_data=0xCAFE, mem_write=1 -> mem_we=1, mem_wdata=0xCAFE while req; mdr unchanged after ack.
- Timeout: fetch with no ack -> mem_req falls after 15 req cycles; timeout_err=1 and stays 1; instruction unchanged; a new fetch still completes normally.
- Boundaries: ack on the 15th req cycle -> captured, timeout_err=0. Spurious ack in IDLE -> no register change.
- Reset mid-access: reset low during ACCESS -> mem_req=0, instruction=0, busy=0 immediately, without waiting for a clock edge.
